// File: rtl/quad_speed_sampler.sv
// quad_speed_sampler: X4 quadrature decoder with a fixed-length count window.
// Every PERIOD clocks the signed edge count of the window is handed to the
// downstream speed filter over a req/ack handshake (enable/over).
module quad_speed_sampler #(
  parameter int unsigned PERIOD  = 50000,
  parameter logic [31:0] CNT_SAT = 32'h7FFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        run,
  output logic [31:0] dataout,
  output logic        enable,
  input  logic        over,
  output logic        ovf,
  output logic        missed,
  output logic        glitch
);

  localparam int unsigned   CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] TC = CW'(PERIOD - 1);

  // Saturation limits held in 34 bits so acc + step can never wrap before
  // it is compared against them.
  localparam logic signed [33:0] SAT_P = $signed({2'b00, CNT_SAT});
  localparam logic signed [33:0] SAT_N = -SAT_P;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_CLR
  } state_t;

  // Input path registers
  logic        r_a_meta, r_a_sync;
  logic        r_b_meta, r_b_sync;
  logic [1:0]  r_prev;
  logic        r_glitch;

  // Count window registers
  logic [31:0]   r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_ovf;

  // Handshake registers
  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_dataout;
  logic        r_missed;

  // Combinational decode / datapath
  logic [1:0]         w_cur;
  logic signed [1:0]  w_step;
  logic               w_illegal;
  logic signed [33:0] w_sum;
  logic [31:0]        w_sat;
  logic               w_clamp;
  logic               w_close;
  logic               w_take;
  logic               w_miss;

  assign w_cur = {r_a_sync, r_b_sync};

  // Two-flop synchronizers, previous-state register and sticky glitch flag.
  // NOTE: clocked state is written with <= so every flop samples the values
  // from before the edge; a blocking = here would collapse the sync chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_meta <= 1'b0;
      r_a_sync <= 1'b0;
      r_b_meta <= 1'b0;
      r_b_sync <= 1'b0;
      r_prev   <= 2'b00;
      r_glitch <= 1'b0;
    end else begin
      r_a_meta <= enc_a;
      r_a_sync <= r_a_meta;
      r_b_meta <= enc_b;
      r_b_sync <= r_b_meta;
      r_prev   <= w_cur;
      if (w_illegal) r_glitch <= 1'b1;
    end
  end

  // X4 step decode of {prev,cur}: Gray order 00->01->11->10->00 is +1.
  // NOTE: every output gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    w_step    = 2'sb00;
    w_illegal = 1'b0;
    case ({r_prev, w_cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: w_step = 2'sb01;  // forward
      4'b0100, 4'b1101, 4'b1011, 4'b0010: w_step = 2'sb11;  // reverse
      4'b0011, 4'b1100, 4'b0110, 4'b1001: w_illegal = 1'b1;  // both bits moved
      default: ;
    endcase
  end

  assign w_sum = $signed({{2{r_acc[31]}}, r_acc}) + $signed({{32{w_step[1]}}, w_step});

  // Clamp acc + step to +/-CNT_SAT; this value is both the next accumulator
  // and, on the terminal cycle, the sample, so the closing step lands once.
  always_comb begin
    w_sat   = w_sum[31:0];
    w_clamp = 1'b0;
    if (w_sum > SAT_P) begin
      w_sat   = SAT_P[31:0];
      w_clamp = 1'b1;
    end else if (w_sum < SAT_N) begin
      w_sat   = SAT_N[31:0];
      w_clamp = 1'b1;
    end
  end

  assign w_close = run && (r_cnt == TC);

  // Window counter and accumulator; both held at zero while run is low so
  // the first window after enabling is a full PERIOD long.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (!run) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      if (w_clamp) r_ovf <= 1'b1;
      if (w_close) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sat;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Handshake next state: a close is only accepted from IDLE; CLR waits for
  // over to drop so enable is never raised into a still-high acknowledge.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_close) begin
          w_take      = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ:   if (over) w_state_nxt = S_CLR;
      S_CLR:   if (!over) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_miss = w_close && (r_state != S_IDLE);

  // Handshake state register, sample capture and sticky missed flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_dataout <= '0;
      r_missed  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) r_dataout <= w_sat;
      if (w_miss) r_missed <= 1'b1;
    end
  end

  assign enable  = (r_state == S_REQ);
  assign dataout = r_dataout;
  assign ovf     = r_ovf;
  assign missed  = r_missed;
  assign glitch  = r_glitch;

endmodule

// File: tb/tb_quad_speed_sampler.sv
// Bench for quad_speed_sampler with PERIOD=16 and CNT_SAT=10. A scoreboard
// queue receives the expected sample of each window as it is stimulated; a
// monitor pops and compares on every rising enable. A filter model drives
// over. Cycle k is the negedge after run rose; a pin change made in cycle k
// reaches the accumulator on the edge closing cycle k+2, and window w closes
// on the edge closing cycle 16*w+15.
module tb_quad_speed_sampler;

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
    logic        missed;
    logic        glitch;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enc_a;
  logic        enc_b;
  logic        run;
  logic [31:0] dataout;
  logic        enable;
  logic        over;
  logic        ovf;
  logic        missed;
  logic        glitch;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  int   pos = 0;          // position in the Gray cycle 00,01,11,10
  logic long_hold = 1'b0;  // next acknowledge is held for 20 cycles

  quad_speed_sampler #(
    .PERIOD (16),
    .CNT_SAT(32'd10)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .enc_a  (enc_a),
    .enc_b  (enc_b),
    .run    (run),
    .dataout(dataout),
    .enable (enable),
    .over   (over),
    .ovf    (ovf),
    .missed (missed),
    .glitch (glitch)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic o, input logic m, input logic g);
    exp_t e;
    e.data   = d;
    e.ovf    = o;
    e.missed = m;
    e.glitch = g;
    exp_q.push_back(e);
  endtask

  task automatic drive_pins();
    case (pos)
      0:       {enc_a, enc_b} = 2'b00;
      1:       {enc_a, enc_b} = 2'b01;
      2:       {enc_a, enc_b} = 2'b11;
      default: {enc_a, enc_b} = 2'b10;
    endcase
  endtask

  task automatic fwd();
    pos = (pos + 1) % 4;
    drive_pins();
  endtask

  task automatic rev();
    pos = (pos + 3) % 4;
    drive_pins();
  endtask

  task automatic both_toggle();
    pos = (pos + 2) % 4;
    drive_pins();
  endtask

  // Filter model: over rises the cycle after the capture edge and falls the
  // cycle after enable drops; in long-hold mode it stays high 20 cycles.
  initial begin
    logic en_prev;
    int   hold_cnt;
    over     = 1'b0;
    en_prev  = 1'b0;
    hold_cnt = 0;
    forever begin
      @(negedge clk);
      if (hold_cnt > 0) begin
        hold_cnt--;
      end else begin
        over = en_prev;
        if (over && long_hold) begin
          hold_cnt  = 19;
          long_hold = 1'b0;
        end
      end
      en_prev = enable;
    end
  end

  // Monitor: compare each presented sample against the scoreboard, and
  // check dataout stays frozen while enable is held.
  initial begin
    logic        en_q;
    logic [31:0] held;
    exp_t        e;
    en_q = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (enable && !en_q) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_sample: got 0x%08h, expected no sample (t=%0t)", dataout, $time);
        end else begin
          e = exp_q.pop_front();
          check("sample_data", dataout, e.data);
          check("sample_flags_ovf_missed_glitch", 32'({ovf, missed, glitch}),
                32'({e.ovf, e.missed, e.glitch}));
        end
        held = dataout;
      end else if (enable && en_q) begin
        check("dataout_stable", dataout, held);
      end
      en_q = enable;
    end
  end

  // Directed stimulus
  initial begin
    rst   = 1'b1;
    run   = 1'b0;
    enc_a = 1'b0;
    enc_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dataout", dataout, 32'd0);
    check("reset_enable",  32'(enable), 32'd0);
    check("reset_flags",   32'({ovf, missed, glitch}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run = 1'b1;

    for (int k = 0; k <= 175; k++) begin
      // scoreboard entries, one per window that reaches the filter
      case (k)
        0:       push(32'd5,         1'b0, 1'b0, 1'b0);  // 5 forward edges
        16:      push(32'd0,         1'b0, 1'b0, 1'b0);  // idle window
        32:      push(32'hFFFF_FFF9, 1'b0, 1'b0, 1'b0);  // 7 reverse edges
        48:      push(32'd3,         1'b0, 1'b0, 1'b0);  // last edge on terminal cycle
        64:      push(32'd0,         1'b0, 1'b0, 1'b0);  // terminal edge not repeated
        80:      push(32'd3,         1'b0, 1'b0, 1'b1);  // 3 legal + 1 illegal
        96:      push(32'd2,         1'b0, 1'b0, 1'b1);  // sample held through long ack
        128:     push(32'd1,         1'b0, 1'b1, 1'b1);  // window after the missed one
        144:     push(32'd10,        1'b1, 1'b1, 1'b1);  // 15 edges clamp to 10
        default: ;
      endcase

      // encoder pins
      if (k inside {1, 3, 5, 7, 9})               fwd();
      if (k inside {32, 34, 36, 38, 40, 42, 44})  rev();
      if (k inside {50, 54, 61})                  fwd();
      if (k inside {82, 85, 88})                  fwd();
      if (k == 91)                                both_toggle();
      if (k inside {97, 100, 115, 130})           fwd();
      if (k >= 142 && k <= 156)                   fwd();
      if (k == 100) long_hold = 1'b1;

      // long acknowledge: window 7 is discarded, window 6 sample stays put
      if (k == 120) begin
        check("hold_enable_low",   32'(enable), 32'd0);
        check("hold_dataout_kept", dataout, 32'd2);
      end
      if (k == 128) begin
        check("missed_set",         32'(missed), 32'd1);
        check("missed_dataout_kept", dataout, 32'd2);
        check("missed_enable_low",  32'(enable), 32'd0);
      end
      if (k == 132) check("enable_low_while_over", 32'(enable), 32'd0);

      // one-cycle reset while the clamped sample is in REQ
      if (k == 160) rst = 1'b1;
      if (k == 161) begin
        rst = 1'b0;
        check("midreq_reset_enable",  32'(enable), 32'd0);
        check("midreq_reset_dataout", dataout, 32'd0);
        check("midreq_reset_ovf",     32'(ovf), 32'd0);
        check("midreq_reset_missed",  32'(missed), 32'd0);
        check("midreq_reset_glitch",  32'(glitch), 32'd0);
      end
      if (k == 170) check("post_reset_no_glitch", 32'(glitch), 32'd0);

      @(negedge clk);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
